boruss_control_unit: RTL and testbench
======================================

# boruss_control_unit

Program sequencer for the Boruss CPU. It drives the 8-bit address of the combinational program ROM and consumes the returned byte each step. It decodes the three-class instruction set (NOP, JMP, LOAD immediate) and holds the accumulator `reg_a`, which drives the LED bank. An optional step prescaler slows execution so LED patterns are visible on hardware.

## Interface

Parameters:
- `STEP_DIV`, default 1: clock cycles per machine step; legal range 1..65535.
- `RESET_PC`, default 8'h00: program counter value after reset.

Ports:
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `run`, in, 1: execution enable. Low freezes the prescaler, PC, FSM and all registers.
- `rom_address`, out, 8: ROM address; combinationally equal to `pc`.
- `rom_data`, in, 8: ROM read data; combinational function of `rom_address`.
- `reg_a`, out, 8: accumulator; LED drive.
- `pc`, out, 8: current program counter.
- `state`, out, 1: 0 = FETCH, 1 = JMP_TARGET.
- `jmp_taken`, out, 1: one-cycle pulse when a jump completes.
- `instr_count`, out, 16: completed-instruction counter; wraps at 16'hFFFF to 0.

## Operation

- **Instruction encoding** (decided):
  - 8'h00 = NOP.
  - 8'h80 = JMP; the operand is in the next byte.
  - Any other byte = LOAD immediate: the byte value is written to `reg_a`.
- **Prescaler:**
  - Counter `div_cnt` runs 0..STEP_DIV-1 while `run`=1.
  - `step` = `run` && (`div_cnt` == STEP_DIV-1).
  - `div_cnt` returns to 0 on `step`.
  - When `run`=0, `div_cnt` holds its value.
  - With STEP_DIV=1, `step` = `run`.
- **FSM** (acts only on `step`):
  - FETCH, `rom_data`=8'h00: `pc`←`pc`+1, `instr_count`+1, stay in FETCH.
  - FETCH, `rom_data`=8'h80: `pc`←`pc`+1, go to JMP_TARGET. `instr_count` is unchanged.
  - FETCH, any other value: `reg_a`←`rom_data`, `pc`←`pc`+1, `instr_count`+1, stay in FETCH.
  - JMP_TARGET: `pc`←`rom_data`, `jmp_taken`←1 for one cycle, `instr_count`+1, go to FETCH.
- **Arithmetic:** `pc` increment is modulo 256 (8'hFF+1 = 8'h00). A JMP opcode at 8'hFF therefore takes its operand from address 8'h00.
- **`jmp_taken`:** registered, 0 in every cycle other than the one following the JMP_TARGET step edge.
- **Reset values:** `pc`=RESET_PC, `rom_address`=RESET_PC, `reg_a`=8'h00, `state`=FETCH, `jmp_taken`=0, `instr_count`=0, `div_cnt`=0.
- **Reset behaviour:** assertion clears all registers immediately, independent of `clk`. This includes reset asserted in JMP_TARGET, which discards the pending jump.
- **Jump to own opcode address:** legal; the block loops forever with one `jmp_taken` pulse per two steps.

## Timing

- The ROM is combinational: `rom_data` for the current `pc` is sampled on the same edge that ends the step. There is no wait state.
- Latency is measured from the step edge.
- **LOAD:** `reg_a` shows the new value in the cycle after the edge.
- **NOP:** one step.
- **JMP:** two steps.
  - At STEP_DIV=1, a JMP at address N executes on edges k and k+1.
  - After edge k+1, `pc` = target and `jmp_taken`=1 for that single cycle.
- **Prescaler:** with STEP_DIV=D and `run` held high, consecutive steps are exactly D cycles apart. The first step after reset occurs on the D-th rising edge.
- **`run` deassertion:**
  - Deasserting `run` in the same cycle as a would-be step suppresses that step.
  - On reassertion, counting resumes from the held `div_cnt`.
- **Outputs:** all outputs except `rom_address` are registered. `rom_address` = `pc` with no extra logic.

## Test plan

- **LOAD/NOP sequence:** STEP_DIV=1, ROM {00:01, 01:00, 02:00, 03:02, 04:00, 05:00, 06:04}, release reset. Required: `reg_a` = 01 after edge 1, 02 after edge 4, 04 after edge 7; `instr_count`=7 after edge 7.
- **Jump:** ROM 18:80, 19:00, `pc` reaching 8'h18. Required: `state`=1 after edge k; after edge k+1, `pc`=8'h00 and `jmp_taken` is high for exactly one cycle; `reg_a` unchanged.
- **Wrap-around:** ROM FF:80, 00:10, RESET_PC=8'hFF. Required: after 2 steps, `pc`=8'h10 and `instr_count`=1.
- **Prescaler:** STEP_DIV=4, ROM 00:01, 01:02, 02:04. Required: `reg_a` changes to 01, 02, 04 on edges 4, 8, 12, and is stable in between.
- **Freeze in JMP_TARGET:** `run`=0 for 10 cycles while in JMP_TARGET. Required: `pc`, `state`, `reg_a`, `instr_count` are constant and `jmp_taken`=0. After `run`=1, the jump completes on the next step.
- **Asynchronous reset mid-jump:** pulse `rst_n` low between clock edges while in JMP_TARGET. Required: `pc`=RESET_PC, `state`=0, `reg_a`=0, `instr_count`=0 before the next edge; no `jmp_taken` pulse.

Source files
------------

// File: rtl/boruss_control_unit.sv
// boruss_control_unit: program sequencer for the Boruss CPU; fetches from a combinational
// ROM, decodes NOP/JMP/LOAD and holds the LED accumulator, with an optional step prescaler.
module boruss_control_unit #(
    parameter int          STEP_DIV = 1,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [7:0]  rom_address,
    input  logic [7:0]  rom_data,
    output logic [7:0]  reg_a,
    output logic [7:0]  pc,
    output logic        state,
    output logic        jmp_taken,
    output logic [15:0] instr_count
);
    typedef enum logic {FETCH = 1'b0, JMP_TARGET = 1'b1} state_t;
    localparam logic [15:0] DIV_MAX = 16'(STEP_DIV - 1);
    state_t      cur, nxt;
    logic [15:0] div_cnt, cnt_nxt;
    logic [7:0]  pc_nxt, a_nxt;
    logic        step, jmp_nxt;
    assign step        = run && (div_cnt == DIV_MAX);
    assign rom_address = pc;
    assign state       = cur;
    always_comb begin
        nxt     = cur;
        pc_nxt  = pc;
        a_nxt   = reg_a;
        cnt_nxt = instr_count;
        jmp_nxt = 1'b0;
        if (step) begin
            if (cur == JMP_TARGET) begin
                pc_nxt  = rom_data;
                nxt     = FETCH;
                cnt_nxt = instr_count + 16'd1;
                jmp_nxt = 1'b1;
            end else begin
                pc_nxt  = pc + 8'd1;
                nxt     = (rom_data == 8'h80) ? JMP_TARGET : FETCH;
                cnt_nxt = (rom_data == 8'h80) ? instr_count : instr_count + 16'd1;
                a_nxt   = (rom_data == 8'h00 || rom_data == 8'h80) ? reg_a : rom_data;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= FETCH;
            pc          <= RESET_PC;
            reg_a       <= 8'h00;
            instr_count <= 16'h0000;
            jmp_taken   <= 1'b0;
            div_cnt     <= 16'h0000;
        end else begin
            cur         <= nxt;
            pc          <= pc_nxt;
            reg_a       <= a_nxt;
            instr_count <= cnt_nxt;
            jmp_taken   <= jmp_nxt;
            div_cnt     <= !run ? div_cnt : (step ? 16'h0000 : div_cnt + 16'd1);
        end
    end
endmodule

// File: tb/tb_boruss_control_unit.sv
// tb_boruss_control_unit: directed checks of three sequencer configurations
// (default, RESET_PC=FF wrap-around, STEP_DIV=4 prescaler).
module tb_boruss_control_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;

    logic        rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0;
    logic        run0 = 1'b1, run1 = 1'b1, run2 = 1'b1;
    logic [7:0]  addr0, addr1, addr2, data0, data1, data2;
    logic [7:0]  a0, a1, a2, pc0, pc1, pc2;
    logic        st0, st1, st2, jt0, jt1, jt2;
    logic [15:0] ic0, ic1, ic2;
    logic [7:0]  rom0 [256];
    logic [7:0]  rom1 [256];
    logic [7:0]  rom2 [256];
    assign data0 = rom0[addr0];
    assign data1 = rom1[addr1];
    assign data2 = rom2[addr2];

    boruss_control_unit #(.STEP_DIV(1), .RESET_PC(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n0), .run(run0), .rom_address(addr0), .rom_data(data0),
        .reg_a(a0), .pc(pc0), .state(st0), .jmp_taken(jt0), .instr_count(ic0));
    boruss_control_unit #(.STEP_DIV(1), .RESET_PC(8'hFF)) u1 (
        .clk(clk), .rst_n(rst_n1), .run(run1), .rom_address(addr1), .rom_data(data1),
        .reg_a(a1), .pc(pc1), .state(st1), .jmp_taken(jt1), .instr_count(ic1));
    boruss_control_unit #(.STEP_DIV(4), .RESET_PC(8'h00)) u2 (
        .clk(clk), .rst_n(rst_n2), .run(run2), .rom_address(addr2), .rom_data(data2),
        .reg_a(a2), .pc(pc2), .state(st2), .jmp_taken(jt2), .instr_count(ic2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 8'h00;
            rom1[i] = 8'h00;
            rom2[i] = 8'h00;
        end
        rom0[8'h00] = 8'h01; rom0[8'h03] = 8'h02; rom0[8'h06] = 8'h04;
        rom0[8'h07] = 8'h80; rom0[8'h08] = 8'h18;
        rom0[8'h18] = 8'h80; rom0[8'h19] = 8'h00;
        rom1[8'hFF] = 8'h80; rom1[8'h00] = 8'h10;
        rom2[8'h00] = 8'h01; rom2[8'h01] = 8'h02; rom2[8'h02] = 8'h04;
        tick();
        tick();
        chk("rst_pc", 16'(pc0), 16'h00);
        chk("rst_addr", 16'(addr0), 16'h00);
        chk("rst_reg_a", 16'(a0), 16'h00);
        chk("rst_state", 16'(st0), 16'h0);
        chk("rst_jmp", 16'(jt0), 16'h0);
        chk("rst_count", ic0, 16'h0000);
        chk("rst_pc_ff", 16'(pc1), 16'h00FF);
        chk("rst_addr_ff", 16'(addr1), 16'h00FF);

        // LOAD/NOP sequence
        rst_n0 = 1'b1;
        tick();
        chk("load1_a", 16'(a0), 16'h01);
        chk("load1_pc", 16'(pc0), 16'h01);
        tick(); tick();
        chk("nop_a", 16'(a0), 16'h01);
        chk("nop_count", ic0, 16'd3);
        tick();
        chk("load2_a", 16'(a0), 16'h02);
        tick(); tick(); tick();
        chk("load3_a", 16'(a0), 16'h04);
        chk("load3_count", ic0, 16'd7);
        tick();
        chk("jmp1_state", 16'(st0), 16'h1);
        chk("jmp1_pc", 16'(pc0), 16'h08);
        chk("jmp1_count", ic0, 16'd7);
        tick();
        chk("jmp1_done_pc", 16'(pc0), 16'h18);
        chk("jmp1_done_pulse", 16'(jt0), 16'h1);
        chk("jmp1_done_count", ic0, 16'd8);
        tick();
        chk("jmp2_state", 16'(st0), 16'h1);
        chk("jmp2_pc", 16'(pc0), 16'h19);
        chk("jmp2_pulse_low", 16'(jt0), 16'h0);

        // freeze in JMP_TARGET
        run0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("frz_pc", 16'(pc0), 16'h19);
            chk("frz_state", 16'(st0), 16'h1);
            chk("frz_a", 16'(a0), 16'h04);
            chk("frz_count", ic0, 16'd8);
            chk("frz_jmp", 16'(jt0), 16'h0);
        end
        run0 = 1'b1;
        tick();
        chk("jmp2_done_pc", 16'(pc0), 16'h00);
        chk("jmp2_done_pulse", 16'(jt0), 16'h1);
        chk("jmp2_done_a", 16'(a0), 16'h04);
        chk("jmp2_done_state", 16'(st0), 16'h0);
        chk("jmp2_done_count", ic0, 16'd9);
        tick();
        chk("post_jmp_pulse", 16'(jt0), 16'h0);
        chk("post_jmp_a", 16'(a0), 16'h01);
        chk("post_jmp_count", ic0, 16'd10);

        // asynchronous reset while in JMP_TARGET
        for (int i = 0; i < 7; i++) tick();
        chk("jmp3_state", 16'(st0), 16'h1);
        chk("jmp3_pc", 16'(pc0), 16'h08);
        #2 rst_n0 = 1'b0;
        #1;
        chk("arst_pc", 16'(pc0), 16'h00);
        chk("arst_state", 16'(st0), 16'h0);
        chk("arst_a", 16'(a0), 16'h00);
        chk("arst_count", ic0, 16'h0000);
        #1 rst_n0 = 1'b1;
        tick();
        chk("arst_no_pulse", 16'(jt0), 16'h0);
        chk("arst_next_pc", 16'(pc0), 16'h01);
        chk("arst_next_a", 16'(a0), 16'h01);

        // wrap-around jump from 8'hFF
        rst_n1 = 1'b1;
        tick();
        chk("wrap_state", 16'(st1), 16'h1);
        chk("wrap_pc_mid", 16'(pc1), 16'h00);
        chk("wrap_count_mid", ic1, 16'd0);
        tick();
        chk("wrap_pc", 16'(pc1), 16'h10);
        chk("wrap_count", ic1, 16'd1);
        chk("wrap_pulse", 16'(jt1), 16'h1);
        chk("wrap_a", 16'(a1), 16'h00);

        // prescaler STEP_DIV=4
        rst_n2 = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            chk("presc_a", 16'(a2), (e < 4) ? 16'h00 : (e < 8) ? 16'h01 : (e < 12) ? 16'h02 : 16'h04);
        end
        chk("presc_count", ic2, 16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
